activation_skew_feeder: RTL
===========================

// Module: activation_skew_feeder
// PURPOSE
//   Operand feeder directly upstream of the systolic PE array, alongside the row scheduler.
//   Buffers an N x N activation matrix written row-vector by row-vector via valid/ready.
//   On start, streams it into the array's N row inputs with diagonal skew.
//   Array row r sees column r of the matrix delayed by r beats.
//   Each beat is held BEAT_CYCLES enabled cycles, matching the scheduler's row-enable cadence.
// PARAMETERS
//   MATRIX_SIZE  2   N: array rows/cols, matrix dimension
//   DATA_SIZE    32  bits per activation element
//   BEAT_CYCLES  4   enabled clk cycles each skew beat is held (>=1)
// PORTS
//   clk             in   1          clock, rising edge
//   reset           in   1          asynchronous, active-high
//   general_enable  in   1          global advance; 0 freezes all state and outputs
//   wr_valid        in   1          write-side valid
//   wr_ready        out  1          write-side ready
//   wr_data         in   N*D        activation row vector; slice [c*D +: D] = A[w][c]
//   start           in   1          single-cycle request to begin streaming
//   busy            out  1          1 in STREAM and DONE states
//   a_out           out  N*D        slice [r*D +: D] = operand for array row r
//   a_valid         out  N          per-row operand valid
//   beat_strobe     out  1          1 on first cycle of every beat
//   done            out  1          one-cycle pulse after the final beat
// BEHAVIOUR
//   Reset values: wr_ready=1, busy=0, a_out=0, a_valid=0, beat_strobe=0, done=0.
//   Reset also sets wr_count=0 and state=LOAD; buffer contents are don't-care.
//   Outputs are registered and update only on cycles with general_enable=1.
//   States: LOAD -> FULL -> STREAM -> DONE -> LOAD.
//   LOAD:
//     - wr_ready=1; a write is accepted when wr_valid&wr_ready&general_enable.
//     - Accepted data is stored as A[wr_count]; wr_count increments.
//     - After write N-1 is accepted: state -> FULL, wr_ready deasserts next cycle.
//   FULL:
//     - wr_ready=0; wr_valid is ignored and no data is overwritten.
//     - start & general_enable -> STREAM.
//   start outside FULL (including LOAD with a partial buffer) is ignored, never queued.
//   start in the same cycle as the final write is ignored; FULL is entered first.
//   STREAM timing (start accepted at edge T):
//     - Beat b (0..2N-2) occupies enabled cycles T+1+b*BEAT_CYCLES ..
//       T+(b+1)*BEAT_CYCLES.
//     - Row r: if 0 <= b-r <= N-1, a_out[r] = A[b-r][r] and a_valid[r] = 1.
//       Otherwise a_out[r] = 0 and a_valid[r] = 0.
//     - beat_strobe=1 on each beat's first cycle.
//     - Counters: cyc_cnt wraps at BEAT_CYCLES-1; beat_cnt ranges 0..2N-2.
//       Width is clog2(2N) bits; no overflow.
//   DONE (cycle after final beat):
//     - a_out=0, a_valid=0, done=1 for exactly one enabled cycle.
//     - Then LOAD with wr_count=0; wr_ready=1 the following cycle.
//   general_enable=0 mid-STREAM: counters hold; outputs hold their last values; a done pulse stretches.
//   Reset mid-STREAM: all outputs return to reset values immediately; buffer is considered empty.
//   busy=1 from T+1 through the DONE cycle inclusive.
// TESTING (N=2, D=8, BEAT_CYCLES=4)
//   Write 16'h0201 then 16'h0403 -> wr_ready=0 after 2nd write; state FULL.
//   start at T -> T+1..4: a_out={00,01}, a_valid=01.
//     T+5..8: {02,03}, a_valid=11.
//     T+9..12: {04,00}, a_valid=10.
//     T+13: done=1, a_valid=00.
//   start after only 1 write -> no stream, a_valid stays 0.
//     Second write then start -> normal stream.
//   wr_valid held high in FULL/STREAM -> no extra accepts.
//     Matrix unchanged; next load begins after done.
//   general_enable low 3 cycles during beat 1 -> beat 1 lasts 7 clk; done delayed by 3.
//   reset asserted at T+6 -> a_valid=0, busy=0 immediately; wr_ready=1.
//     A fresh load and stream then behave exactly as the first test.

Source files
------------

// File: rtl/activation_skew_feeder_if.sv
// Write-side and stream-side signals of the activation skew feeder.
//   master : producer of matrix rows and start, consumer of the skewed stream
//   slave  : the feeder itself
//   wr_valid/wr_ready/wr_data : row-vector write handshake (wr_data slice c = A[w][c])
//   start/busy/done           : stream control and status
//   a_out/a_valid/beat_strobe : per-row skewed operands towards the PE array
interface activation_skew_feeder_if #(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32
);
    logic                              wr_valid;
    logic                              wr_ready;
    logic [MATRIX_SIZE*DATA_SIZE-1:0]  wr_data;
    logic                              start;
    logic                              busy;
    logic [MATRIX_SIZE*DATA_SIZE-1:0]  a_out;
    logic [MATRIX_SIZE-1:0]            a_valid;
    logic                              beat_strobe;
    logic                              done;

    modport master (
        output wr_valid, wr_data, start,
        input  wr_ready, busy, a_out, a_valid, beat_strobe, done
    );

    modport slave (
        input  wr_valid, wr_data, start,
        output wr_ready, busy, a_out, a_valid, beat_strobe, done
    );
endinterface

// File: rtl/activation_skew_feeder.sv
// Buffers an N x N activation matrix (one row vector per write) and, on start,
// streams it into the PE array rows with diagonal skew: array row r receives
// column r of the matrix delayed by r beats, each beat held BEAT_CYCLES
// enabled cycles.
//   clk            : rising-edge clock
//   reset          : asynchronous, active-high
//   general_enable : global advance; low freezes all state and outputs
//   bus            : activation_skew_feeder_if slave modport (write + stream)
module activation_skew_feeder #(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned BEAT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     general_enable,
    activation_skew_feeder_if.slave  bus
);

    localparam int unsigned ROW_W  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int unsigned BEAT_W = $clog2(2 * MATRIX_SIZE);
    localparam int unsigned CYC_W  = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned VEC_W  = MATRIX_SIZE * DATA_SIZE;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(MATRIX_SIZE - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * MATRIX_SIZE - 2);
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(BEAT_CYCLES - 1);

    typedef enum logic [1:0] {LOAD, FULL, STREAM, DONE} state_t;

    state_t             state, state_d;
    logic [ROW_W-1:0]   wr_count, wr_count_d;
    logic [BEAT_W-1:0]  beat_cnt, beat_d, next_beat;
    logic [CYC_W-1:0]   cyc_cnt, cyc_d;
    logic               wr_ready_q, wr_ready_d;
    logic               busy_q, busy_d;
    logic [VEC_W-1:0]   a_out_q, a_out_d;
    logic [MATRIX_SIZE-1:0] a_valid_q, a_valid_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic               load_beat;
    logic               wr_accept;
    int                 skew_row;

    logic [VEC_W-1:0]   mem [MATRIX_SIZE];

    assign wr_accept = (state == LOAD) && bus.wr_valid && wr_ready_q;

    // Matrix buffer: no reset, contents are only read after a complete load
    always_ff @(posedge clk) begin
        if (general_enable && wr_accept) begin
            mem[wr_count] <= bus.wr_data;
        end
    end

    // State and registered outputs; everything freezes while general_enable is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            wr_count   <= '0;
            beat_cnt   <= '0;
            cyc_cnt    <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            a_out_q    <= '0;
            a_valid_q  <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
        end else if (general_enable) begin
            state      <= state_d;
            wr_count   <= wr_count_d;
            beat_cnt   <= beat_d;
            cyc_cnt    <= cyc_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            a_out_q    <= a_out_d;
            a_valid_q  <= a_valid_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
        end
    end

    // Next state, counters and next output values
    always_comb begin
        state_d    = state;
        wr_count_d = wr_count;
        beat_d     = beat_cnt;
        cyc_d      = cyc_cnt;
        wr_ready_d = wr_ready_q;
        busy_d     = busy_q;
        a_out_d    = a_out_q;
        a_valid_d  = a_valid_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        load_beat  = 1'b0;
        next_beat  = beat_cnt;
        skew_row   = 0;

        case (state)
            LOAD: begin
                if (wr_accept) begin
                    if (wr_count == LAST_ROW) begin
                        state_d    = FULL;
                        wr_ready_d = 1'b0;
                        wr_count_d = '0;
                    end else begin
                        wr_count_d = wr_count + ROW_W'(1);
                    end
                end
            end
            FULL: begin
                if (bus.start) begin
                    state_d   = STREAM;
                    busy_d    = 1'b1;
                    beat_d    = '0;
                    cyc_d     = '0;
                    next_beat = '0;
                    load_beat = 1'b1;
                end
            end
            STREAM: begin
                if (cyc_cnt == LAST_CYC) begin
                    cyc_d = '0;
                    if (beat_cnt == LAST_BEAT) begin
                        state_d   = DONE;
                        a_out_d   = '0;
                        a_valid_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        beat_d    = beat_cnt + BEAT_W'(1);
                        next_beat = beat_cnt + BEAT_W'(1);
                        load_beat = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_cnt + CYC_W'(1);
                end
            end
            DONE: begin
                state_d    = LOAD;
                busy_d     = 1'b0;
                wr_ready_d = 1'b1;
                wr_count_d = '0;
            end
            default: state_d = LOAD;
        endcase

        // Skewed operand selection: row r carries A[beat-r][r] while in range
        if (load_beat) begin
            strobe_d  = 1'b1;
            a_out_d   = '0;
            a_valid_d = '0;
            for (int r = 0; r < int'(MATRIX_SIZE); r++) begin
                skew_row = int'(next_beat) - r;
                if (skew_row >= 0 && skew_row < int'(MATRIX_SIZE)) begin
                    a_out_d[r*DATA_SIZE +: DATA_SIZE] =
                        mem[ROW_W'(skew_row)][r*DATA_SIZE +: DATA_SIZE];
                    a_valid_d[r] = 1'b1;
                end
            end
        end
    end

    assign bus.wr_ready    = wr_ready_q;
    assign bus.busy        = busy_q;
    assign bus.a_out       = a_out_q;
    assign bus.a_valid     = a_valid_q;
    assign bus.beat_strobe = strobe_q;
    assign bus.done        = done_q;

endmodule
